// File: rtl/midi_pkg.sv
// Shared types for the MIDI parser: parse states, status nibbles and decoded event kinds.
// Pure declarations, no logic, no latency.
// No flow control of its own; used by midi_parser and midi_status_decode.
package midi_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_D1, ST_D2, ST_SKIP} state_t;
    typedef enum logic [1:0] {EV_NONE, EV_NOTE_OFF, EV_NOTE_ON, EV_CC} evt_t;

    localparam logic [3:0] NIB_NOTE_OFF = 4'h8;
    localparam logic [3:0] NIB_NOTE_ON  = 4'h9;
    localparam logic [3:0] NIB_POLY_AT  = 4'hA;
    localparam logic [3:0] NIB_CTRL     = 4'hB;
    localparam logic [3:0] NIB_PROG     = 4'hC;
    localparam logic [3:0] NIB_CHAN_AT  = 4'hD;
    localparam logic [3:0] NIB_BEND     = 4'hE;

    localparam logic [7:0] REALTIME_MIN = 8'hF8;
    localparam logic [7:0] SYSCOM_MIN   = 8'hF0;

endpackage

// File: rtl/midi_status_decode.sv
// Combinational classification of a MIDI byte seen on the status path.
// Zero latency; evt reports CC only when MIDI_CC_EN is defined.
// No backpressure: pure function of the input byte.
module midi_status_decode
    import midi_pkg::*;
(
    input  logic [7:0] status,
    output logic       is_realtime,
    output logic       is_syscom,
    output logic       one_data,
    output logic       two_data,
    output evt_t       evt
);

    always_comb begin
        is_realtime = (status >= REALTIME_MIN);
        is_syscom   = (status >= SYSCOM_MIN) && !is_realtime;
        one_data    = 1'b0;
        two_data    = 1'b0;
        evt         = EV_NONE;
        case (status[7:4])
            NIB_PROG, NIB_CHAN_AT: one_data = 1'b1;
            NIB_POLY_AT, NIB_BEND: two_data = 1'b1;
            NIB_NOTE_OFF: begin
                two_data = 1'b1;
                evt      = EV_NOTE_OFF;
            end
            NIB_NOTE_ON: begin
                two_data = 1'b1;
                evt      = EV_NOTE_ON;
            end
            NIB_CTRL: begin
                two_data = 1'b1;
`ifdef MIDI_CC_EN
                evt      = EV_CC;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/midi_parser.sv
// MIDI byte parser with running status and channel filter; CC events need MIDI_CC_EN.
// Latency: strobes and CHAN/KEY/VAL valid the cycle after the final data byte is sampled.
// No backpressure: one byte per DV cycle, back-to-back accepted, no stall.
module midi_parser
    import midi_pkg::*;
#(
    parameter bit         OMNI        = 1'b1,
    parameter logic [3:0] CHANNEL_SEL = 4'd0
)
(
    input  logic       CLK,
    input  logic       CLR,
    input  logic       CE,
    input  logic       DV,
    input  logic [7:0] DATA,
    output logic       NOTE_ON,
    output logic       NOTE_OFF,
    output logic       CC,
    output logic [3:0] CHAN,
    output logic [6:0] KEY,
    output logic [6:0] VAL
);

    state_t     state;
    evt_t       run_evt;
    logic       run_two;
    logic [3:0] run_chan;
    logic [6:0] key_t;

    logic dec_rt, dec_sys, dec_one, dec_two;
    evt_t dec_evt;

    midi_status_decode u_dec (
        .status      (DATA),
        .is_realtime (dec_rt),
        .is_syscom   (dec_sys),
        .one_data    (dec_one),
        .two_data    (dec_two),
        .evt         (dec_evt)
    );

    logic take, is_data, complete, accept;
    logic fire_on, fire_off, fire_cc, fire;

    // Realtime bytes are dropped before they can touch any state.
    assign take     = CE && DV && !dec_rt;
    assign is_data  = !DATA[7];
    assign complete = take && is_data && (state == ST_D2);
    assign accept   = OMNI || (run_chan == CHANNEL_SEL);

    assign fire_on  = complete && accept && (run_evt == EV_NOTE_ON) && (DATA[6:0] != 7'd0);
    assign fire_off = complete && accept &&
                      ((run_evt == EV_NOTE_OFF) || ((run_evt == EV_NOTE_ON) && (DATA[6:0] == 7'd0)));
`ifdef MIDI_CC_EN
    assign fire_cc  = complete && accept && (run_evt == EV_CC);
`else
    assign fire_cc  = 1'b0;
`endif
    assign fire     = fire_on || fire_off || fire_cc;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state    <= ST_IDLE;
            run_evt  <= EV_NONE;
            run_two  <= 1'b0;
            run_chan <= 4'd0;
            key_t    <= 7'd0;
            NOTE_ON  <= 1'b0;
            NOTE_OFF <= 1'b0;
            CHAN     <= 4'd0;
            KEY      <= 7'd0;
            VAL      <= 7'd0;
        end else begin
            NOTE_ON  <= fire_on;
            NOTE_OFF <= fire_off;
            if (fire) begin
                CHAN <= run_chan;
                KEY  <= key_t;
                VAL  <= DATA[6:0];
            end
            if (take) begin
                if (!is_data) begin
                    // A new status always aborts any partial message.
                    if (dec_one || dec_two) begin
                        state    <= ST_D1;
                        run_evt  <= dec_evt;
                        run_two  <= dec_two;
                        run_chan <= DATA[3:0];
                    end else if (dec_sys) begin
                        state    <= ST_SKIP;
                        run_evt  <= EV_NONE;
                    end
                end else begin
                    case (state)
                        ST_D1: begin
                            key_t <= DATA[6:0];
                            if (run_two) state <= ST_D2;
                        end
                        ST_D2:   state <= ST_D1;
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef MIDI_CC_EN
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) CC <= 1'b0;
        else     CC <= fire_cc;
    end
`else
    assign CC = 1'b0;
`endif

endmodule

// File: tb/tb_midi_parser.sv
// Bench for midi_parser: an OMNI instance and a channel-2-only instance share one byte stream,
// checked each cycle against a message-level model of MIDI running status.
module tb_midi_parser;

    logic       clk = 1'b0;
    logic       clr, ce, dv;
    logic [7:0] data;

    logic       on_a, off_a, cc_a, on_b, off_b, cc_b;
    logic [3:0] chan_a, chan_b;
    logic [6:0] key_a, val_a, key_b, val_b;

    always #5 clk = ~clk;

    midi_parser #(.OMNI(1'b1), .CHANNEL_SEL(4'd0)) dut_a (
        .CLK(clk), .CLR(clr), .CE(ce), .DV(dv), .DATA(data),
        .NOTE_ON(on_a), .NOTE_OFF(off_a), .CC(cc_a),
        .CHAN(chan_a), .KEY(key_a), .VAL(val_a)
    );

    midi_parser #(.OMNI(1'b0), .CHANNEL_SEL(4'd2)) dut_b (
        .CLK(clk), .CLR(clr), .CE(ce), .DV(dv), .DATA(data),
        .NOTE_ON(on_b), .NOTE_OFF(off_b), .CC(cc_b),
        .CHAN(chan_b), .KEY(key_b), .VAL(val_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Model: running status byte (0 = none), count of data bytes gathered, first data byte.
    logic [7:0]  rs;
    int          npend;
    logic [6:0]  d0;
    // Expected {NOTE_ON, NOTE_OFF, CC, CHAN, KEY, VAL} for instance 0 (omni) and 1 (ch 2).
    logic [20:0] exp_o [2];

    task automatic model_reset();
        rs    = 8'h00;
        npend = 0;
        d0    = 7'd0;
        for (int i = 0; i < 2; i++) exp_o[i] = 21'd0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [3:0] hi;
        logic       ev_on, ev_off, ev_cc;
        if (b >= 8'hF8) return;
        if (b >= 8'hF0) begin
            rs = 8'h00; npend = 0; return;
        end
        if (b[7]) begin
            rs = b; npend = 0; return;
        end
        if (rs == 8'h00) return;
        hi = rs[7:4];
        if (hi == 4'hC || hi == 4'hD) return;
        if (npend == 0) begin
            d0 = b[6:0]; npend = 1; return;
        end
        npend  = 0;
        ev_on  = (hi == 4'h9) && (b != 8'h00);
        ev_off = (hi == 4'h8) || ((hi == 4'h9) && (b == 8'h00));
`ifdef MIDI_CC_EN
        ev_cc  = (hi == 4'hB);
`else
        ev_cc  = 1'b0;
`endif
        for (int i = 0; i < 2; i++)
            if ((ev_on || ev_off || ev_cc) && (i == 0 || rs[3:0] == 4'd2))
                exp_o[i] = {ev_on, ev_off, ev_cc, rs[3:0], d0, b[6:0]};
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "/omni"}, {11'd0, on_a, off_a, cc_a, chan_a, key_a, val_a}, {11'd0, exp_o[0]});
        check_eq({tag, "/ch2"},  {11'd0, on_b, off_b, cc_b, chan_b, key_b, val_b}, {11'd0, exp_o[1]});
    endtask

    task automatic step(input logic c, input logic v, input logic [7:0] b, input string tag);
        @(negedge clk);
        ce = c; dv = v; data = b;
        for (int i = 0; i < 2; i++) exp_o[i][20:18] = 3'b000;
        if (c && v) model_byte(b);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        clr = 1'b1; ce = 1'b0; dv = 1'b0; data = 8'h00;
        model_reset();
        #2;
        check_outputs(tag);
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input string tag);
        step(1'b1, 1'b1, b, tag);
    endtask

    initial begin
        logic [7:0] b;
        logic [3:0] hi, lo;
        int         r;
        clr = 1'b0; ce = 1'b0; dv = 1'b0; data = 8'h00;
        model_reset();

        do_reset("reset");

        send(8'h90, "on_s"); send(8'h3C, "on_k"); send(8'h64, "on_v");
        step(1'b0, 1'b0, 8'h00, "on_clear");

        send(8'h91, "rs_s"); send(8'h40, "rs_k1"); send(8'h7F, "rs_v1");
        send(8'h40, "rs_k2"); send(8'h00, "rs_v0");

        send(8'h80, "off_s"); send(8'hF8, "off_rt1"); send(8'h3C, "off_k");
        send(8'hFE, "off_rt2"); send(8'h10, "off_v");

        send(8'h93, "f3_s"); send(8'h3C, "f3_k"); send(8'h64, "f3_v");
        send(8'h92, "f2_s"); send(8'h3C, "f2_k"); send(8'h64, "f2_v");

        send(8'h90, "sx_s"); send(8'h3C, "sx_k"); send(8'hF0, "sx_f0");
        send(8'h7E, "sx_d1"); send(8'h45, "sx_d2"); send(8'h30, "sx_d3");
        send(8'hC0, "pc_s"); send(8'h05, "pc_d1"); send(8'h06, "pc_d2");

        send(8'hB0, "cc_s"); send(8'h07, "cc_k"); send(8'h50, "cc_v");

        // CE low mid-message: byte ignored, strobe from previous edge still clears.
        send(8'h92, "ce_s"); send(8'h11, "ce_k"); step(1'b0, 1'b1, 8'h22, "ce_off");
        send(8'h33, "ce_v"); step(1'b0, 1'b1, 8'h44, "ce_clr");

        send(8'h90, "clr_s"); send(8'h3C, "clr_k");
        do_reset("clr_mid");
        send(8'h64, "clr_v");

        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                b = 8'h00;
            end else if (r < 62) begin
                b = 8'($urandom_range(0, 127));
            end else if (r < 90) begin
                hi = 4'($urandom_range(8, 14));
                lo = 4'($urandom_range(0, 3));
                b  = {hi, lo};
            end else begin
                b = 8'($urandom_range(240, 255));
            end
            if ($urandom_range(0, 499) == 0)
                do_reset("rnd_reset");
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 7), b, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/midi_parser.md
# midi_parser

Byte-level MIDI message parser sitting directly downstream of the UART receiver. Consumes one received byte per data-valid strobe, tracks running status, filters by channel, and emits single-cycle note-on / note-off (and optionally control-change) events with registered channel, key and value fields for the voice allocator.

## Interface
- OMNI, default 1: 1 = accept all channels; 0 = accept only CHANNEL_SEL.
- CHANNEL_SEL, default 0: 4-bit MIDI channel accepted when OMNI = 0.
- CLK  in  1  system clock; all state changes on rising edge.
- CLR  in  1  reset, asynchronous, active-high.
- CE  in  1  clock enable; when low, no state, field or strobe changes except strobe clear.
- DV  in  1  byte valid from UART receiver, one CLK cycle per byte; ignored when CE = 0.
- DATA  in  8  received byte, valid when DV = 1.
- NOTE_ON  out  1  one-cycle strobe: note-on event accepted.
- NOTE_OFF  out  1  one-cycle strobe: note-off event accepted (incl. note-on with velocity 0).
- CC  out  1  one-cycle strobe: control change accepted (only with MIDI_CC_EN, else tied 0).
- CHAN  out  4  channel of last emitted event.
- KEY  out  7  note number or controller number of last event.
- VAL  out  7  velocity or controller value of last event.

## Operation
- Byte classes: status = DATA[7] = 1; data = DATA[7] = 0.
- Realtime bytes 0xF8–0xFF: discarded, no effect on state or running status.
- System common 0xF0–0xF7: clear running status, enter SKIP.
- Channel status 0x80–0xEF: latch status byte as running status, enter D1.
- States: IDLE (no running status), D1 (await first data byte), D2 (await second data byte), SKIP (discard data bytes until next status).
- IDLE/SKIP + data byte: discarded, stay.
- D1 + data byte: latch into KEY_t; if status is 0xC_/0xD_ (one data byte) return to D1, no event; else go D2.
- D2 + data byte: message complete; classify, emit event if accepted; return to D1 (running status retained).
- Status byte in D1/D2: aborts partial message, no event, new status takes effect.
- Event rules at D2 completion, subject to channel filter: 0x9n with value ≠ 0 → NOTE_ON; 0x9n with value 0 or 0x8n → NOTE_OFF; 0xBn → CC (if enabled); 0xAn, 0xEn → no event.
- Channel filter rejection: message parsed normally, no strobe, fields unchanged.
- CHAN/KEY/VAL update only on an emitted event; hold otherwise.

## Timing
- Reset: state IDLE, running status cleared, NOTE_ON/NOTE_OFF/CC = 0, CHAN = 0, KEY = 0, VAL = 0.
- Latency: strobe and fields valid in the cycle immediately after the CLK edge sampling DV = 1 with the final data byte.
- Strobes high exactly one CLK cycle, cleared next edge even if CE = 0.
- Back-to-back DV on consecutive cycles must be supported; no stall, no backpressure.
- CLR mid-message: partial message and running status lost; no event.

## Configuration
- MIDI_CC_EN defined: 0xBn messages produce CC strobe with KEY = controller, VAL = value.
- MIDI_CC_EN undefined: 0xBn parsed and discarded like 0xAn; CC output tied 0.

## Structure
- Package midi_pkg: state encoding (IDLE, D1, D2, SKIP), status nibble constants (NOTE_OFF 4'h8, NOTE_ON 4'h9, POLY_AT 4'hA, CTRL 4'hB, PROG 4'hC, CHAN_AT 4'hD, BEND 4'hE), realtime threshold 8'hF8.
- Sub-module midi_status_decode: combinational classification of a status byte (realtime, system common, one-data-byte, two-data-byte, event type).

## Test plan
- 0x90,0x3C,0x64 → one NOTE_ON, CHAN 0, KEY 0x3C, VAL 0x64.
- Running status 0x91,0x40,0x7F,0x40,0x00 → NOTE_ON (CHAN 1, KEY 0x40, VAL 0x7F) then NOTE_OFF (KEY 0x40, VAL 0).
- 0x80,0xF8,0x3C,0xFE,0x10 → single NOTE_OFF KEY 0x3C, VAL 0x10; realtime bytes invisible.
- OMNI = 0, CHANNEL_SEL = 2: 0x93,0x3C,0x64 → no strobe, fields unchanged; 0x92,0x3C,0x64 → NOTE_ON CHAN 2.
- 0x90,0x3C then 0xF0,0x7E,0x45 then 0x30 → no events; 0xC0,0x05,0x06 → no events, stays D1.
- 0xB0,0x07,0x50 → CC KEY 0x07 VAL 0x50 with MIDI_CC_EN; no strobe without; CLR after 0x90,0x3C then 0x64 → no event.
